// File: rtl/sim_checkpoint_monitor.sv
// ============================================================================
// sim_checkpoint_monitor: compares DUT channels against a (cycle, value) table.
// Optional CKPT_MASK_EN adds per-entry channel masks.  Rev 1.0
// ============================================================================
`default_nettype none

module sim_checkpoint_monitor #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_CKPT = 8,
    parameter int CYC_W    = 16,
    parameter int ERR_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_CKPT)-1:0]     cfg_idx,
    input  logic [CYC_W-1:0]                cfg_cycle,
    input  logic [NUM_CH*DATA_W-1:0]        cfg_exp,
    input  logic [NUM_CH-1:0]               cfg_mask,
    input  logic [$clog2(NUM_CKPT+1)-1:0]   cfg_num,
    input  logic [NUM_CH*DATA_W-1:0]        dut_obs,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [ERR_W-1:0]                err_cnt,
    output logic [$clog2(NUM_CKPT)-1:0]     fail_idx,
    output logic                            fail_vld
);

    localparam int c_idx_w = $clog2(NUM_CKPT);
    localparam int c_num_w = $clog2(NUM_CKPT+1);
    localparam int c_cnt_w = $clog2(NUM_CH+1);
    localparam int c_sum_w = ((ERR_W > c_cnt_w) ? ERR_W : c_cnt_w) + 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [ERR_W-1:0]   c_err_max = {ERR_W{1'b1}};
    localparam logic [c_num_w-1:0] c_num_max = c_num_w'(NUM_CKPT);

    logic [1:0]               r_state;
    logic [c_idx_w-1:0]       r_ptr;
    logic [c_idx_w-1:0]       r_last;
    logic [CYC_W-1:0]         r_cyc;
    logic [ERR_W-1:0]         r_err;
    logic [c_idx_w-1:0]       r_fail_idx;
    logic                     r_fail_vld;

    logic [CYC_W-1:0]         r_tab_cyc [NUM_CKPT];
    logic [NUM_CH*DATA_W-1:0] r_tab_exp [NUM_CKPT];

    logic [CYC_W-1:0]         w_cur_cyc;
    logic [NUM_CH*DATA_W-1:0] w_cur_exp;
    logic [NUM_CH-1:0]        w_mask;
    logic [NUM_CH-1:0]        w_ne;
    logic [c_cnt_w-1:0]       w_ne_cnt;
    logic [c_cnt_w-1:0]       w_mask_cnt;
    logic [c_cnt_w-1:0]       w_add;
    logic [c_sum_w-1:0]       w_sum;
    logic [ERR_W-1:0]         w_err_next;
    logic                     w_hit;
    logic                     w_miss;
    logic                     w_wr_ok;
    logic [c_num_w-1:0]       w_num;

    assign w_wr_ok = rst && cfg_we && (r_state != c_run);

    // Table storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_tab_cyc[cfg_idx] <= cfg_cycle;
            r_tab_exp[cfg_idx] <= cfg_exp;
        end
    end

`ifdef CKPT_MASK_EN
    logic [NUM_CH-1:0] r_tab_mask [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_tab_mask[cfg_idx] <= cfg_mask;
        end
    end

    assign w_mask = r_tab_mask[r_ptr];
`else
    logic w_unused_mask;
    assign w_unused_mask = ^cfg_mask;
    assign w_mask        = '1;
`endif

    assign w_cur_cyc = r_tab_cyc[r_ptr];
    assign w_cur_exp = r_tab_exp[r_ptr];
    assign w_hit     = (r_state == c_run) && (r_cyc == w_cur_cyc);
    assign w_miss    = (r_state == c_run) && (r_cyc >  w_cur_cyc);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_ne[i] = w_mask[i] &&
                (w_cur_exp[i*DATA_W +: DATA_W] != dut_obs[i*DATA_W +: DATA_W]);
        end
    endgenerate

    always_comb begin
        w_ne_cnt   = '0;
        w_mask_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ne_cnt   = w_ne_cnt   + c_cnt_w'(w_ne[i]);
            w_mask_cnt = w_mask_cnt + c_cnt_w'(w_mask[i]);
        end
    end

    // A missed entry is charged as if every enabled channel had mismatched.
    assign w_add      = w_hit ? w_ne_cnt : (w_miss ? w_mask_cnt : '0);
    assign w_sum      = c_sum_w'(r_err) + c_sum_w'(w_add);
    assign w_err_next = (w_sum > c_sum_w'(c_err_max)) ? c_err_max : w_sum[ERR_W-1:0];
    assign w_num      = (cfg_num > c_num_max) ? c_num_max : cfg_num;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_idle;
            r_ptr      <= '0;
            r_last     <= '0;
            r_cyc      <= '0;
            r_err      <= '0;
            r_fail_idx <= '0;
            r_fail_vld <= 1'b0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        r_ptr      <= '0;
                        r_cyc      <= '0;
                        r_err      <= '0;
                        r_fail_idx <= '0;
                        r_fail_vld <= 1'b0;
                        r_last     <= c_idx_w'(w_num - c_num_w'(1));
                        r_state    <= (w_num == '0) ? c_done : c_run;
                    end
                end
                c_run: begin
                    if (r_cyc != {CYC_W{1'b1}}) begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                    if (w_hit || w_miss) begin
                        r_err <= w_err_next;
                        if ((w_add != '0) && !r_fail_vld) begin
                            r_fail_idx <= r_ptr;
                            r_fail_vld <= 1'b1;
                        end
                        if (r_ptr == r_last) begin
                            r_state <= c_done;
                        end else begin
                            r_ptr <= r_ptr + c_idx_w'(1);
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy     = (r_state == c_run);
    assign done     = (r_state == c_done);
    assign pass     = done && (r_err == '0);
    assign err_cnt  = r_err;
    assign fail_idx = r_fail_idx;
    assign fail_vld = r_fail_vld;

endmodule

`default_nettype wire

// File: doc/sim_checkpoint_monitor.md
# sim_checkpoint_monitor

Synthesizable, parametrised checkpoint monitor for generated-design regression. It compares a bundle of DUT observation channels against a programmable table of (cycle, expected value) checkpoints after a run is started. It accumulates a saturating mismatch count and reports pass/fail. It sits beside the generated top module in the bench and replaces hand-coded per-cycle value checks.

## Interface
Parameters:
- NUM_CH, 4, number of observed channels
- DATA_W, 8, width of each channel
- NUM_CKPT, 8, checkpoint table depth
- CYC_W, 16, cycle counter width
- ERR_W, 8, error counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin run; honoured only in IDLE or DONE
- cfg_we  in  1  table write strobe; ignored unless IDLE or DONE
- cfg_idx  in  $clog2(NUM_CKPT)  table entry to write
- cfg_cycle  in  CYC_W  checkpoint cycle
- cfg_exp  in  NUM_CH*DATA_W  expected values; channel i at bits [i*DATA_W +: DATA_W]
- cfg_mask  in  NUM_CH  per-channel compare enable; used only with CKPT_MASK_EN
- cfg_num  in  $clog2(NUM_CKPT+1)  active entry count; sampled on the start edge
- dut_obs  in  NUM_CH*DATA_W  observed DUT channels, same packing as cfg_exp
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  done && err_cnt==0
- err_cnt  out  ERR_W  accumulated mismatching channels, saturating
- fail_idx  out  $clog2(NUM_CKPT)  index of the first failing checkpoint
- fail_vld  out  1  fail_idx is valid

## Operation
- Reset (rst==0 at an edge): state IDLE; busy=0, done=0, pass=0, err_cnt=0, fail_idx=0, fail_vld=0, ptr=0, cyc=0. Table contents are not reset.
- Reset during RUN aborts the run immediately. It takes priority over start and cfg_we.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - latch cfg_num;
  - clear err_cnt, fail_vld, fail_idx and ptr; set cyc=0;
  - go to RUN, or to DONE if cfg_num==0 (pass=1).
- RUN, every cycle:
  - if cyc==table[ptr].cycle: compare each channel of dut_obs to table[ptr].exp; add the mismatch count to err_cnt; advance ptr.
  - if cyc>table[ptr].cycle (entry missed, non-ascending table): add NUM_CH to err_cnt; advance ptr; no compare.
  - otherwise no action.
  - cyc increments and saturates at 2^CYC_W-1.
- Entry ptr==latched cfg_num-1 consumed -> DONE next cycle.
- First checkpoint with a nonzero mismatch sets fail_idx=ptr and fail_vld=1. Later failures do not overwrite them.
- err_cnt saturates at 2^ERR_W-1; it never wraps.
- DONE holds all results until start or reset.
- cfg_we in RUN is dropped; the table is unchanged.
- A start pulse in RUN is ignored.
- cfg_num>NUM_CKPT is clamped to NUM_CKPT.

## Timing
- cyc=k during the (k+1)-th RUN cycle. dut_obs is sampled at the rising edge that ends that cycle.
- Compare result is visible on err_cnt/fail_vld one edge after sampling.
- The final checkpoint's err_cnt, done and pass update on the same edge.
- Start-to-busy latency: 1 edge. cfg_num==0 start-to-done latency: 1 edge.
- A table write takes effect at the write edge. start and cfg_we on the same edge: the write lands, and the run uses the new entry.
- At most one checkpoint is consumed per cycle. A missed-entry chain drains at one entry per cycle.

## Configuration
- CKPT_MASK_EN defined:
  - cfg_mask is stored per entry;
  - a channel whose mask bit is 0 never counts as a mismatch;
  - a missed entry adds popcount(mask) instead of NUM_CH.
- CKPT_MASK_EN undefined:
  - no mask storage;
  - cfg_mask is ignored;
  - all channels are always compared.

## Test plan
Defaults throughout; channel order is a,b,c,d (d uses bit 0 only).
- Match run: entry0 = cycle 6, exp {0,0,0,1}; entry1 = cycle 56, exp {48,1,0,0}; cfg_num=2; DUT drives exactly those values -> done at run cycle 57, err_cnt=0, pass=1, fail_vld=0.
- Mismatch: same table, but a=47 at cycle 56 -> err_cnt=1, pass=0, fail_idx=1, fail_vld=1.
- Missed entry: entry0 cycle 10, entry1 cycle 5 -> entry1 adds 4 at cycle 11; err_cnt=4; fail_idx=1.
- Saturation: ERR_W=2, 3 entries each fully mismatching -> err_cnt=3 and holds there.
- Reset mid-run: rst low at run cycle 20 -> next edge busy=0, done=0, err_cnt=0. A new start with cfg_num=0 -> done=1, pass=1 after 1 edge.
- Mask (CKPT_MASK_EN only): mask=4'b0001, a wrong -> err_cnt=0. Without the macro -> err_cnt=1.
